// File: rtl/imem_server.sv
// Instruction-memory responder: owns the PC and a synchronous instruction RAM, loaded in LOAD, fetched in RUN.
// Optional misaligned-redirect flag enabled by defining IMEM_ALIGN_CHECK_EN.
module imem_server #(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re_i,
  input  logic        load_mode_i,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        misalign_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_LOAD, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pco_q, pco_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic        mem_we;
  logic [AW-1:0] widx, ridx;
  logic [31:0] mem [DEPTH];

  // Address bits above the RAM index alias; they are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{waddr_i[31:AW+2], waddr_i[1:0], redirect_pc_i[1:0]};

  assign widx = waddr_i[AW+1:2];
  assign ridx = pc_q[AW+1:2];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pco_d   = pco_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    mem_we  = 1'b0;
    case (state_q)
      S_LOAD: begin
        pc_d   = RESET_PC;
        mem_we = we_i;
        if (!load_mode_i) state_d = S_RUN;
      end
      default: begin
        if (redirect_i) begin
          pc_d    = {redirect_pc_i[31:2], 2'b00};
          instr_d = NOP;
          valid_d = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
          mis_d   = |redirect_pc_i[1:0];
`else
          mis_d   = 1'b0;
`endif
        end else if (re_i) begin
          instr_d = mem[ridx];
          pco_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pco_q   <= 32'h0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[widx] <= wdata_i;
  end

  assign instr_o    = instr_q;
  assign pc_o       = pco_q;
  assign valid_o    = valid_q;
  assign misalign_o = mis_q;
endmodule

// File: tb/tb_imem_server.sv
// Directed bench for imem_server with a behavioural fetch model checked every cycle.
module tb_imem_server;
  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_ALIGN_CHECK_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re_i = 1'b0, load_mode_i = 1'b1, we_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] waddr_i = '0, wdata_i = '0, redirect_pc_i = '0;
  logic [31:0] instr_o, pc_o;
  logic        valid_o, misalign_o;

  int n_chk = 0;
  int n_fail = 0;

  imem_server #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .re_i(re_i), .load_mode_i(load_mode_i), .we_i(we_i),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .instr_o(instr_o), .pc_o(pc_o),
    .valid_o(valid_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: word-addressed memory plus the architectural fetch rules.
  logic [31:0] m_mem [DEPTH];
  logic        m_run;
  logic [31:0] m_pc, m_instr, m_pco;
  logic        m_valid, m_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_pc = 0; m_instr = NOP; m_pco = 0; m_valid = 0; m_mis = 0;
    end else if (!m_run) begin
      if (we_i) m_mem[(waddr_i / 4) % DEPTH] = wdata_i;
      m_pc = 0;
      if (!load_mode_i) m_run = 1;
    end else if (redirect_i) begin
      m_pc = redirect_pc_i - (redirect_pc_i % 4);
      m_instr = NOP; m_valid = 0;
      m_mis = MIS_EN && (redirect_pc_i % 4 != 0);
    end else if (re_i) begin
      m_instr = m_mem[(m_pc / 4) % DEPTH];
      m_pco = m_pc; m_valid = 1;
      m_pc = m_pc + 4;
    end
  end

  always @(negedge clk) begin
    chk("instr_o", instr_o, m_instr);
    chk("pc_o", pc_o, m_pco);
    chk("valid_o", {31'b0, valid_o}, {31'b0, m_valid});
    chk("misalign_o", {31'b0, misalign_o}, {31'b0, m_mis});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] i, input logic [31:0] p,
                            input logic v);
    chk({tag, ".instr"}, instr_o, i);
    chk({tag, ".pc"}, pc_o, p);
    chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, v});
  endtask

  task automatic expect_reset(input string tag);
    expect_out(tag, NOP, 32'h0, 1'b0);
    chk({tag, ".mis"}, {31'b0, misalign_o}, 32'h0);
  endtask

  initial begin
    cyc(); cyc();
    expect_reset("por");
    rst_n = 1'b1;
    // Load all words: 0..2 hold 11,22,33, the rest a recognisable pattern.
    for (int i = 0; i < DEPTH; i++) begin
      we_i = 1'b1; waddr_i = i * 4;
      wdata_i = (i == 0) ? 32'd11 : (i == 1) ? 32'd22 : (i == 2) ? 32'd33 : 32'hA000_0000 + i;
      cyc();
    end
    we_i = 1'b0; load_mode_i = 1'b0; re_i = 1'b1;
    cyc();                                   // LOAD -> RUN
    expect_out("idle_run", NOP, 32'h0, 1'b0);
    cyc(); expect_out("f0", 32'd11, 32'h0, 1'b1);
    cyc(); expect_out("f1", 32'd22, 32'h4, 1'b1);
    re_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); expect_out("stall", 32'd22, 32'h4, 1'b1);
    end
    re_i = 1'b1;
    cyc(); expect_out("f2", 32'd33, 32'h8, 1'b1);

    // Redirect wins over a stall on the same edge.
    redirect_i = 1'b1; redirect_pc_i = 32'h8; re_i = 1'b0;
    cyc(); expect_out("bubble", NOP, 32'h8, 1'b0);
    redirect_i = 1'b0; re_i = 1'b1;
    cyc(); expect_out("redir_tgt", 32'd33, 32'h8, 1'b1);

    redirect_i = 1'b1; redirect_pc_i = 32'h6;
    cyc(); chk("mis_set", {31'b0, misalign_o}, {31'b0, MIS_EN});
    redirect_i = 1'b0;
    cyc(); expect_out("mis_tgt", 32'd22, 32'h4, 1'b1);
    chk("mis_sticky", {31'b0, misalign_o}, {31'b0, MIS_EN});

    // Write attempt in RUN must not reach the RAM.
    we_i = 1'b1; waddr_i = 32'h0; wdata_i = 32'hDEAD_BEEF;
    cyc(); we_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = DEPTH * 4;
    cyc(); chk("mis_clr", {31'b0, misalign_o}, 32'h0);
    redirect_i = 1'b0;
    cyc(); expect_out("alias", 32'd11, DEPTH * 4, 1'b1);

    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cyc(); redirect_i = 1'b0;
    cyc(); expect_out("top", 32'hA000_0000 + DEPTH - 1, 32'hFFFF_FFFC, 1'b1);
    cyc(); expect_out("wrap", 32'd11, 32'h0, 1'b1);

    // Asynchronous reset mid-fetch, then restart from preserved RAM.
    cyc();
    rst_n = 1'b0; load_mode_i = 1'b1;
    #1 expect_reset("async_rst");
    cyc(); rst_n = 1'b1;
    cyc(); expect_reset("in_load");
    load_mode_i = 1'b0;
    cyc(); cyc();
    expect_out("restart", 32'd11, 32'h0, 1'b1);
    cyc(); expect_out("restart1", 32'd22, 32'h4, 1'b1);

    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
